// File: rtl/sig_trans_gen.sv
// sig_trans_gen: plays back transition records {level, hold} as a sampled
// waveform. Records are queued in a small FIFO; each record drives its level
// on Out for `hold` clk cycles. Back-to-back records play without gaps.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   reset     - synchronous active-high reset
//   In        - record level (W bits)
//   InHold    - record hold count in cycles (W bits, 0 = discard)
//   InValid   - record offered on In/InHold
//   InReady   - block accepts a record this cycle
//   Out       - registered reconstructed waveform
//   Edge      - registered one-cycle flag: Out changed on this edge
//   Active    - playback in progress (state HOLD)
//   Underrun  - sticky: playback finished with no record queued
module sig_trans_gen #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] In,
    input  logic [W-1:0] InHold,
    input  logic         InValid,
    output logic         InReady,
    output logic [W-1:0] Out,
    output logic         Edge,
    output logic         Active,
    output logic         Underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    logic [W-1:0]  lvl_mem_q  [DEPTH];
    logic [W-1:0]  hold_mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  holdcnt_q;
    logic [W-1:0]  out_q;
    logic          edge_q, under_q;
    state_t        state_q;

    logic          push, pop, load, fifo_empty;
    logic [W-1:0]  head_lvl, head_hold;

    // Ready depends only on the registered count, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign InReady    = !reset && (count_q != CW'(DEPTH));
    assign push       = InValid && InReady;
    assign fifo_empty = (count_q == '0);
    assign head_lvl   = lvl_mem_q[rd_ptr_q];
    assign head_hold  = hold_mem_q[rd_ptr_q];

    // Pop whenever the player needs a new record: idle, or on the last
    // cycle of the current hold (gapless reload).
    assign pop  = !fifo_empty && ((state_q == IDLE) || (holdcnt_q == '0));
    assign load = pop && (head_hold != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            holdcnt_q <= '0;
            out_q     <= '0;
            edge_q    <= 1'b0;
            under_q   <= 1'b0;
            state_q   <= IDLE;
        end else begin
            if (push) begin
                lvl_mem_q[wr_ptr_q]  <= In;
                hold_mem_q[wr_ptr_q] <= InHold;
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            // Reloading the same level is not an edge.
            edge_q  <= load && (head_lvl != out_q);

            case (state_q)
                IDLE: begin
                    if (load) begin
                        out_q     <= head_lvl;
                        holdcnt_q <= head_hold - 1'b1;
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (holdcnt_q != '0) begin
                        holdcnt_q <= holdcnt_q - 1'b1;
                    end else if (pop) begin
                        if (load) begin
                            out_q     <= head_lvl;
                            holdcnt_q <= head_hold - 1'b1;
                        end else begin
                            // Zero-hold successor ends playback cleanly.
                            state_q   <= IDLE;
                        end
                    end else begin
                        state_q <= IDLE;
                        under_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Out      = out_q;
    assign Edge     = edge_q;
    assign Active   = (state_q == HOLD);
    assign Underrun = under_q;

endmodule

// File: tb/tb_sig_trans_gen.sv
module tb_sig_trans_gen;
    localparam int W     = 12;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] In, InHold;
    logic         InValid;
    logic         InReady;
    logic [W-1:0] Out;
    logic         Edge, Active, Underrun;

    sig_trans_gen #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .In(In), .InHold(InHold), .InValid(InValid),
        .InReady(InReady), .Out(Out), .Edge(Edge), .Active(Active), .Underrun(Underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Reference model: a queue of pending records and the number of cycles
    // still to show the current level (0 = not playing).
    int           mq_l[$];
    int           mq_h[$];
    int           m_left  = 0;
    logic [W-1:0] m_out   = '0;
    logic         m_edge  = 1'b0;
    logic         m_under = 1'b0;
    logic         m_rdy;
    logic         rdy_seen;

    task automatic model_update(input logic v, input logic [W-1:0] l, input logic [W-1:0] h,
                                input logic r);
        logic [W-1:0] prev;
        logic         ready;
        int           hl, hh;
        if (r) begin
            mq_l.delete(); mq_h.delete();
            m_left = 0; m_out = '0; m_edge = 1'b0; m_under = 1'b0;
            return;
        end
        ready = (mq_l.size() < DEPTH);
        prev  = m_out;
        if (m_left > 1) begin
            m_left--;
        end else if (mq_l.size() > 0) begin
            hl = mq_l.pop_front();
            hh = mq_h.pop_front();
            if (hh > 0) begin
                m_out  = hl[W-1:0];
                m_left = hh;
            end else begin
                m_left = 0;
            end
        end else begin
            if (m_left == 1) m_under = 1'b1;
            m_left = 0;
        end
        m_edge = (m_out != prev);
        if (v && ready) begin
            mq_l.push_back(int'(l));
            mq_h.push_back(int'(h));
        end
    endtask

    // Drive one cycle of inputs mid-cycle, capture InReady before the edge,
    // advance the model with the edge, and settle after it.
    task automatic step(input logic v, input logic [W-1:0] l, input logic [W-1:0] h,
                        input logic r);
        InValid = v; In = l; InHold = h; reset = r;
        #1;
        rdy_seen = InReady;
        m_rdy    = !r && (mq_l.size() < DEPTH);
        @(posedge clk);
        model_update(v, l, h, r);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, W'($urandom), W'($urandom_range(1, 9)), 1'b1);
            vectors++;
            if ({Out, Edge, Active, Underrun, rdy_seen} !== {12'h000, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset cyc%0d got Out=%h E=%b A=%b U=%b R=%b want 000/0/0/0/0",
                         i, Out, Edge, Active, Underrun, rdy_seen);
            end
        end
        step(1'b0, '0, '0, 1'b0);
        vectors++;
        if ({Out, Active, Underrun} !== {m_out, (m_left > 0), m_under}) begin
            fails++;
            $display("FAIL reset_ignored got Out=%h A=%b U=%b want %h/%b/%b",
                     Out, Active, Underrun, m_out, m_left > 0, m_under);
        end
    endtask

    task automatic test_single();
        int n_a5a = 0;
        do_reset(3);
        for (int i = 0; i < 9; i++) begin
            if (i == 0) step(1'b1, 12'hA5A, 12'd5, 1'b0);
            else        step(1'b0, '0, '0, 1'b0);
            vectors++;
            if ({Out, Edge, Active, Underrun, rdy_seen} !== {m_out, m_edge, (m_left > 0), m_under, m_rdy}) begin
                fails++;
                $display("FAIL single cyc%0d got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                         Out, Edge, Active, Underrun, rdy_seen, m_out, m_edge, m_left > 0, m_under, m_rdy);
            end
            if (i == 1) begin
                vectors++;
                if ({Out, Edge} !== {12'hA5A, 1'b1}) begin
                    fails++;
                    $display("FAIL single_latency got Out=%h E=%b want A5A/1", Out, Edge);
                end
            end
            if (Active && Out == 12'hA5A) n_a5a++;
        end
        vectors++;
        if ({n_a5a, Out, Underrun} !== {32'd5, 12'hA5A, 1'b1}) begin
            fails++;
            $display("FAIL single_len got cycles=%0d Out=%h U=%b want 5/A5A/1", n_a5a, Out, Underrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] seen[$];
        logic [W-1:0] want[6] = '{12'h001, 12'h001, 12'h002, 12'h002, 12'h002, 12'h003};
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: step(1'b1, 12'h001, 12'd2, 1'b0);
                1: step(1'b1, 12'h002, 12'd3, 1'b0);
                2: step(1'b1, 12'h003, 12'd1, 1'b0);
                default: step(1'b0, '0, '0, 1'b0);
            endcase
            vectors++;
            if ({Out, Edge, Active, Underrun, rdy_seen} !== {m_out, m_edge, (m_left > 0), m_under, m_rdy}) begin
                fails++;
                $display("FAIL b2b cyc%0d got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                         Out, Edge, Active, Underrun, rdy_seen, m_out, m_edge, m_left > 0, m_under, m_rdy);
            end
            if (Active) seen.push_back(Out);
        end
        vectors++;
        if (seen.size() != 6 || seen[0] !== want[0] || seen[2] !== want[2] || seen[5] !== want[5] ||
            seen[1] !== want[1] || seen[3] !== want[3] || seen[4] !== want[4]) begin
            fails++;
            $display("FAIL b2b_seq got %0d active samples want 001,001,002,002,002,003", seen.size());
        end
    endtask

    task automatic test_full();
        int acc = 0;
        int acc6_cyc = -1;
        do_reset(2);
        for (int i = 0; i < 640; i++) begin
            step(acc < 6, W'(acc + 16), 12'd100, 1'b0);
            if (rdy_seen && acc < 6) begin
                acc++;
                if (acc == 6) acc6_cyc = i;
            end
            vectors++;
            if ({Out, Edge, Active, Underrun, rdy_seen} !== {m_out, m_edge, (m_left > 0), m_under, m_rdy}) begin
                fails++;
                $display("FAIL full cyc%0d got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                         Out, Edge, Active, Underrun, rdy_seen, m_out, m_edge, m_left > 0, m_under, m_rdy);
            end
        end
        vectors++;
        if (acc6_cyc != 102) begin
            fails++;
            $display("FAIL full_6th_accept got cycle %0d want 102", acc6_cyc);
        end
    endtask

    task automatic test_zero_hold();
        int n_ff = 0, n_edge = 0, n_123 = 0;
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: step(1'b1, 12'h0FF, 12'd2, 1'b0);
                1: step(1'b1, 12'h123, 12'd0, 1'b0);
                2: step(1'b1, 12'h0FF, 12'd3, 1'b0);
                default: step(1'b0, '0, '0, 1'b0);
            endcase
            vectors++;
            if ({Out, Edge, Active, Underrun, rdy_seen} !== {m_out, m_edge, (m_left > 0), m_under, m_rdy}) begin
                fails++;
                $display("FAIL zero_hold cyc%0d got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                         Out, Edge, Active, Underrun, rdy_seen, m_out, m_edge, m_left > 0, m_under, m_rdy);
            end
            if (Active && Out == 12'h0FF) n_ff++;
            if (Out == 12'h123) n_123++;
            if (Edge) n_edge++;
        end
        vectors++;
        if (n_ff != 5 || n_123 != 0 || n_edge != 1 || Underrun !== 1'b1) begin
            fails++;
            $display("FAIL zero_hold_sum got ff=%0d x123=%0d edges=%0d U=%b want 5/0/1/1",
                     n_ff, n_123, n_edge, Underrun);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            case (i)
                0, 1, 2: step(1'b1, W'(12'h300 + i), 12'd10, 1'b0);
                5:       step(1'b0, '0, '0, 1'b1);
                7:       step(1'b1, 12'h7FF, 12'd1, 1'b0);
                default: step(1'b0, '0, '0, 1'b0);
            endcase
            vectors++;
            if ({Out, Edge, Active, Underrun, rdy_seen} !== {m_out, m_edge, (m_left > 0), m_under, m_rdy}) begin
                fails++;
                $display("FAIL reset_mid cyc%0d got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                         Out, Edge, Active, Underrun, rdy_seen, m_out, m_edge, m_left > 0, m_under, m_rdy);
            end
            if (i == 5) begin
                vectors++;
                if ({Out, Active, Underrun} !== {12'h000, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL reset_mid_clear got %h/%b/%b want 000/0/0", Out, Active, Underrun);
                end
            end
            if (i == 8 || i == 9) begin
                vectors++;
                if ({Out, Active, Underrun} !== {12'h7FF, (i == 8), (i == 9)}) begin
                    fails++;
                    $display("FAIL reset_mid_after cyc%0d got %h/%b/%b", i, Out, Active, Underrun);
                end
            end
        end
    endtask

    task automatic test_max_hold();
        int  n_fff = 0;
        logic edge_at_zero = 1'b0;
        logic seen_zero = 1'b0;
        do_reset(2);
        for (int i = 0; i < 4105; i++) begin
            case (i)
                0: step(1'b1, 12'hFFF, 12'hFFF, 1'b0);
                1: step(1'b1, 12'h000, 12'd1, 1'b0);
                default: step(1'b0, '0, '0, 1'b0);
            endcase
            vectors++;
            if ({Out, Edge, Active, Underrun, rdy_seen} !== {m_out, m_edge, (m_left > 0), m_under, m_rdy}) begin
                fails++;
                $display("FAIL max_hold cyc%0d got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                         Out, Edge, Active, Underrun, rdy_seen, m_out, m_edge, m_left > 0, m_under, m_rdy);
            end
            if (Out == 12'hFFF) n_fff++;
            if (n_fff > 0 && Out == 12'h000 && !seen_zero) begin
                seen_zero    = 1'b1;
                edge_at_zero = Edge;
            end
        end
        vectors++;
        if (n_fff != 4095 || edge_at_zero !== 1'b1) begin
            fails++;
            $display("FAIL max_hold_len got %0d cycles edge=%b want 4095/1", n_fff, edge_at_zero);
        end
    endtask

    task automatic test_random();
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 45), W'($urandom_range(0, 7)),
                 W'($urandom_range(0, 4)), ($urandom_range(0, 299) == 0));
            vectors++;
            if ({Out, Edge, Active, Underrun, rdy_seen} !== {m_out, m_edge, (m_left > 0), m_under, m_rdy}) begin
                fails++;
                $display("FAIL random cyc%0d got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", i,
                         Out, Edge, Active, Underrun, rdy_seen, m_out, m_edge, m_left > 0, m_under, m_rdy);
            end
        end
    endtask

    initial begin
        reset = 1'b1; InValid = 1'b0; In = '0; InHold = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_zero_hold();
        test_reset_mid();
        test_max_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/sig_trans_gen.md
SIG_TRANS_GEN -- requirements
Module: sig_trans_gen

Interface
REQ-001 Parameter W, default 12: sample and hold-count width.
REQ-002 Parameter DEPTH, default 4: record FIFO depth, a power of two, >= 2.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 reset  input  1: reset, synchronous and active-high.
REQ-005 In  input  W: level of the incoming transition record.
REQ-006 InHold  input  W: number of clk cycles that level is driven on Out.
REQ-007 InValid  input  1: record on In/InHold is offered.
REQ-008 InReady  output  1: block accepts a record this cycle.
REQ-009 Out  output  W: reconstructed sampled waveform, registered.
REQ-010 Edge  output  1: registered one-cycle flag, Out differs from its previous value.
REQ-011 Active  output  1: playback in progress, i.e. state HOLD.
REQ-012 Underrun  output  1: sticky flag, playback ran dry.

Function
REQ-013 Record acceptance SHALL occur on a rising edge where InValid=1 and InReady=1; {In, InHold} is written to the FIFO.
REQ-014 InReady SHALL be 1 exactly when FIFO count < DEPTH and reset=0, derived from registered count only.
- No push when full, even if a pop occurs the same cycle.
REQ-015 FIFO SHALL be first-in first-out.
- Count range 0..DEPTH.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop SHALL leave count unchanged.
REQ-016 FSM SHALL have two states, IDLE and HOLD; reset state is IDLE.
REQ-017 IDLE with FIFO non-empty SHALL pop the head record in that cycle.
- hold != 0: Out <= level, holdcnt <= hold-1, next state HOLD.
- hold == 0: record discarded, Out unchanged, stay IDLE.
REQ-018 HOLD with holdcnt != 0 SHALL decrement holdcnt and keep Out.
REQ-019 HOLD with holdcnt == 0 and FIFO non-empty SHALL pop the head record in the same cycle, giving gapless back-to-back playback.
- hold != 0: load as in REQ-017, stay HOLD.
- hold == 0: discard and go IDLE; Underrun is not set.
REQ-020 HOLD with holdcnt == 0 and FIFO empty SHALL go IDLE, set Underrun to 1, and keep Out at its last level.
REQ-021 Each record with hold=N>=1 SHALL appear on Out for exactly N consecutive cycles when its successor is already queued.
REQ-022 Latency: a record accepted at edge k into an empty FIFO while IDLE SHALL appear on Out after edge k+1.
REQ-023 Edge SHALL be 1 in exactly the cycles where the registered Out differs from its value in the previous cycle.
- Reloading an identical level gives Edge=0.
REQ-024 Active SHALL be 1 exactly when the state is HOLD.
REQ-025 holdcnt SHALL be W bits wide; hold=2^W-1 is legal and holds for 2^W-1 cycles.

Reset
REQ-026 Reset SHALL force, on the next edge:
- Out=0, Edge=0, Active=0, Underrun=0
- state IDLE, FIFO count 0, pointers 0, holdcnt 0
REQ-027 InReady SHALL be 0 while reset=1; records offered during reset SHALL be ignored.
REQ-028 Reset asserted mid-playback SHALL discard all queued and in-progress records with no further Out change.
- First record accepted after reset deassertion follows REQ-022.
REQ-029 Underrun SHALL clear only by reset.

Verification
REQ-030 Single record: reset 3 cycles, then push {In=0xA5A, InHold=5} -> Out=0xA5A for exactly 5 cycles from edge k+1, Edge=1 on the first of them, Active=1 for 5 cycles, then Underrun=1 and Out stays 0xA5A.
REQ-031 Back-to-back: push {0x001,2},{0x002,3},{0x003,1} in consecutive cycles -> Out sequence 001,001,002,002,002,003 with no gap; Edge=1 at each level change.
REQ-032 Full FIFO: hold InValid=1 with 6 records of hold=100 -> first is popped at once, 4 are queued, InReady=0 until the first record completes, and the 6th record is accepted in the cycle after the first pop from full.
REQ-033 Zero hold and same level: push {0x0FF,2},{0x123,0},{0x0FF,3} -> Out=0x0FF for 5 cycles, no 0x123, Edge=1 only once, Underrun=1 afterwards.
REQ-034 Reset mid-operation: queue 3 records of hold=10, assert reset at cycle 4 of the first -> Out=0, Active=0, count=0, Underrun=0 next edge; after release, push {0x7FF,1} -> Out=0x7FF one cycle, then Underrun=1.
REQ-035 Max hold: push {0xFFF,0xFFF} then {0x000,1} -> Out=0xFFF for exactly 4095 cycles, then 0x000 with Edge=1.
